// File: rtl/bpred_bht.sv
// Branch history table with target buffer: same-cycle lookup for IF, one resolved update per cycle
// from ID. Optional update/mispredict statistics counters are enabled by defining BPRED_STATS_EN.
module bpred_bht #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        hit_o,
  output logic        predict_o,
  output logic [31:0] predict_addr_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispredict_i,
`ifdef BPRED_STATS_EN
  output logic [31:0] stat_upd_o,
  output logic [31:0] stat_miss_o,
`endif
  input  logic        clear_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [CNT_W-1:0]   r_cnt [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;

  assign w_idx     = pc_i[IDX_W+1:2];
  assign w_tag     = pc_i[TAG_HI:IDX_W+2];
  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[TAG_HI:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Lookup reads only registered state, so a same-cycle update is not visible until next cycle.
  always_comb begin
    hit_o          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    predict_o      = hit_o && r_cnt[w_idx][CNT_W-1];
    predict_addr_o = hit_o ? r_tgt[w_idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= CNT_WNT;
      end
    end else if (clear_i) begin
      r_valid <= '0;
    end else if (upd_valid_i) begin
      if (w_upd_hit) begin
        if (upd_taken_i) begin
          if (r_cnt[w_upd_idx] != CNT_MAX) r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_W'(1);
          r_tgt[w_upd_idx] <= upd_target_i;
        end else if (r_cnt[w_upd_idx] != '0) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_W'(1);
        end
      end else if (upd_taken_i) begin
        // Not-taken misses never allocate; taken misses replace whatever sits at the index.
        r_valid[w_upd_idx] <= 1'b1;
        r_tag[w_upd_idx]   <= w_upd_tag;
        r_tgt[w_upd_idx]   <= upd_target_i;
        r_cnt[w_upd_idx]   <= CNT_WT;
      end
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] r_stat_upd;
  logic [31:0] r_stat_miss;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_upd  <= 32'h0;
      r_stat_miss <= 32'h0;
    end else if (upd_valid_i) begin
      if (r_stat_upd != 32'hFFFF_FFFF) r_stat_upd <= r_stat_upd + 32'd1;
      if (upd_mispredict_i && (r_stat_miss != 32'hFFFF_FFFF)) r_stat_miss <= r_stat_miss + 32'd1;
    end
  end

  assign stat_upd_o  = r_stat_upd;
  assign stat_miss_o = r_stat_miss;

  logic w_unused;
  assign w_unused = ^{pc_i[31:TAG_HI+1], pc_i[1:0], upd_pc_i[31:TAG_HI+1], upd_pc_i[1:0]};
`else
  logic w_unused;
  assign w_unused = ^{pc_i[31:TAG_HI+1], pc_i[1:0], upd_pc_i[31:TAG_HI+1], upd_pc_i[1:0],
                      upd_mispredict_i};
`endif

endmodule

// File: tb/tb_bpred_bht.sv
// Scoreboard bench for bpred_bht (ENTRIES=64, TAG_W=8, CNT_W=2); stats checks need BPRED_STATS_EN.
module tb_bpred_bht;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        predict_o;
  logic [31:0] predict_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispredict_i;
  logic        clear_i;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_upd_o;
  logic [31:0] stat_miss_o;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic        hit;
    logic        pred;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   step_id = 0;

  always #5 clk = ~clk;

  bpred_bht #(
    .ENTRIES(64),
    .TAG_W  (8),
    .CNT_W  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_i            (pc_i),
    .hit_o           (hit_o),
    .predict_o       (predict_o),
    .predict_addr_o  (predict_addr_o),
    .upd_valid_i     (upd_valid_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .upd_mispredict_i(upd_mispredict_i),
`ifdef BPRED_STATS_EN
    .stat_upd_o      (stat_upd_o),
    .stat_miss_o     (stat_miss_o),
`endif
    .clear_i         (clear_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One cycle: drive lookup/update/control just after posedge, queue the expected lookup result.
  task automatic step(input logic r, input logic clr, input logic uv, input logic [31:0] upc,
                      input logic tk, input logic [31:0] tgt, input logic mis,
                      input logic [31:0] pc, input logic eh, input logic ep,
                      input logic [31:0] ea);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    clear_i          = clr;
    upd_valid_i      = uv;
    upd_pc_i         = upc;
    upd_taken_i      = tk;
    upd_target_i     = tgt;
    upd_mispredict_i = mis;
    pc_i             = pc;
    step_id++;
    e.id   = step_id;
    e.hit  = eh;
    e.pred = ep;
    e.addr = ea;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_eq($sformatf("s%0d_hit", e.id), {31'h0, hit_o}, {31'h0, e.hit});
      check_eq($sformatf("s%0d_pred", e.id), {31'h0, predict_o}, {31'h0, e.pred});
      check_eq($sformatf("s%0d_addr", e.id), predict_addr_o, e.addr);
    end
  end

  localparam logic [31:0] PA = 32'h0040_0010;
  localparam logic [31:0] PB = 32'h0040_0110;
  localparam logic [31:0] TA = 32'h0040_0100;
  localparam logic [31:0] TB = 32'h0040_0200;

  initial begin
    rst = 1'b1; clear_i = 1'b0; upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0;
    upd_target_i = '0; upd_mispredict_i = 1'b0; pc_i = PA;
    repeat (2) @(posedge clk);
    //   rst clr uv upc  tk tgt  mis pc   hit pred addr
    step(0, 0, 0, 0,   0, 0,   0, PA, 0, 0, 0);   // 1 after reset
    step(0, 0, 1, PA,  1, TA,  0, PA, 0, 0, 0);   // 2 same-index: pre-update state
    step(0, 0, 1, PA,  0, 0,   0, PA, 1, 1, TA);  // 3 cnt 10 -> 01
    step(0, 0, 1, PA,  0, 0,   0, PA, 1, 0, TA);  // 4 01 -> 00
    step(0, 0, 1, PA,  0, 0,   0, PA, 1, 0, TA);  // 5 00 stays 00
    step(0, 0, 1, PA,  1, TA,  0, PA, 1, 0, TA);  // 6 00 -> 01
    step(0, 0, 1, PA,  1, TA,  0, PA, 1, 0, TA);  // 7 01 -> 10
    step(0, 0, 1, PA,  1, TA,  0, PA, 1, 1, TA);  // 8 10 -> 11
    step(0, 0, 1, PA,  1, TA,  0, PA, 1, 1, TA);  // 9 11 saturates
    step(0, 0, 1, PA,  0, 0,   0, PA, 1, 1, TA);  // 10 11 -> 10
    step(0, 0, 0, 0,   0, 0,   0, PA, 1, 1, TA);  // 11 still taken
    step(0, 0, 0, 0,   0, 0,   0, PB, 0, 0, 0);   // 12 alias misses
    step(0, 0, 1, PB,  1, TB,  0, PB, 0, 0, 0);   // 13 replace entry
    step(0, 0, 0, 0,   0, 0,   0, PA, 0, 0, 0);   // 14 old tag now misses
    step(0, 0, 1, PB,  0, 0,   0, PB, 1, 1, TB);  // 15 weakly taken; NT -> 01
    step(0, 0, 0, 0,   0, 0,   0, PB, 1, 0, TB);  // 16 target kept on NT
    step(0, 0, 1, 32'h14, 0, 32'h55, 0, 32'h14, 0, 0, 0); // 17 NT miss no alloc
    step(0, 0, 0, 0,   0, 0,   0, 32'h14, 0, 0, 0);  // 18
    step(0, 1, 1, 32'h20, 1, 32'h1234, 0, 32'h20, 0, 0, 0); // 19 clear beats update
    step(0, 0, 0, 0,   0, 0,   0, 32'h20, 0, 0, 0);  // 20
    step(0, 0, 0, 0,   0, 0,   0, PB, 0, 0, 0);      // 21 cleared
    step(0, 0, 1, 32'h0040_0013, 1, 32'h0040_0300, 0, PA, 0, 0, 0); // 22 pc[1:0] ignored
    step(0, 0, 0, 0,   0, 0,   0, 32'h0040_0012, 1, 1, 32'h0040_0300); // 23
    step(1, 0, 1, 32'h20, 1, 32'h999, 1, 32'h20, 0, 0, 0); // 24 reset drops update
    step(0, 0, 0, 0,   0, 0,   0, 32'h20, 0, 0, 0);  // 25
    step(0, 0, 0, 0,   0, 0,   0, 32'h0040_0012, 0, 0, 0); // 26 reset invalidated
`ifdef BPRED_STATS_EN
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 32'h40, 0, 0, (i < 3) ? 1'b1 : 1'b0, 32'h40, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0);
    @(negedge clk);
    check_eq("stat_upd", stat_upd_o, 32'd10);
    check_eq("stat_miss", stat_miss_o, 32'd3);
    force dut.r_stat_upd = 32'hFFFF_FFFE;
    #1;
    release dut.r_stat_upd;
    step(0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 0, 0, 0);
    step(0, 0, 1, 32'h40, 0, 0, 0, 32'h40, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0);
    @(negedge clk);
    check_eq("stat_upd_sat", stat_upd_o, 32'hFFFF_FFFF);
`endif
    @(posedge clk);
    #1;
    upd_valid_i = 1'b0;
    clear_i     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("scoreboard_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
